// File: rtl/div_clk_monitor.sv
// Three-channel divided-clock monitor: measures each mon_in period in clk_in cycles,
// locks on LOCK_CNT consecutive matches and flags loss of lock. Optional macro CLK_MON_SYNC_EN.
module div_clk_monitor #(
    parameter int EXP_P0   = 2,
    parameter int EXP_P1   = 4,
    parameter int EXP_P2   = 8,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] mon_in,
    input  logic       err_clr,
    output logic [2:0] lock,
    output logic [2:0] err_pulse,
    output logic [2:0] err_sticky,
    output logic [5:0] period0,
    output logic [5:0] period1,
    output logic [5:0] period2
);
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, TRACK, LOCKED} state_t;

    logic [2:0] samp_src;
    logic [2:0] samp_reg;
    logic [2:0] prev_reg;
    logic [2:0] rise;

`ifdef CLK_MON_SYNC_EN
    logic [2:0] sync1_reg;
    logic [2:0] sync2_reg;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= mon_in;
            sync2_reg <= sync1_reg;
        end
    end
    assign samp_src = sync2_reg;
`else
    assign samp_src = mon_in;
`endif

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            samp_reg <= '0;
            prev_reg <= '0;
        end else begin
            samp_reg <= samp_src;
            prev_reg <= samp_reg;
        end
    end
    assign rise = samp_reg & ~prev_reg;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        localparam int EXP_INT = (gi == 0) ? EXP_P0 : (gi == 1) ? EXP_P1 : EXP_P2;
        localparam logic [5:0] EXP = 6'(EXP_INT);

        state_t     state_reg;
        logic [5:0] cnt_reg;
        logic [3:0] match_reg;
        logic [5:0] period_reg;
        logic       lock_reg;
        logic       pulse_reg;
        logic       sticky_reg;
        logic       is_match;
        logic       timeout;
        logic       err_now;
        logic [5:0] cnt_inc;

        assign is_match = (cnt_reg == EXP);
        // Timeout fires on the edge where the counter steps onto TIMEOUT.
        assign timeout  = !rise[gi] && (cnt_reg == 6'(TIMEOUT - 1));
        assign err_now  = en && (state_reg == LOCKED) &&
                          ((rise[gi] && !is_match) || timeout);
        assign cnt_inc  = (cnt_reg == 6'(TIMEOUT)) ? cnt_reg : cnt_reg + 6'd1;

        always_ff @(posedge clk_in or negedge rst) begin
            if (!rst) begin
                state_reg  <= IDLE;
                cnt_reg    <= '0;
                match_reg  <= '0;
                period_reg <= '0;
                lock_reg   <= 1'b0;
                pulse_reg  <= 1'b0;
                sticky_reg <= 1'b0;
            end else begin
                pulse_reg  <= err_now;
                sticky_reg <= (sticky_reg & ~err_clr) | err_now;
                if (!en) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    match_reg <= '0;
                    lock_reg  <= 1'b0;
                end else begin
                    case (state_reg)
                        IDLE: state_reg <= WAIT_EDGE;
                        WAIT_EDGE: begin
                            if (rise[gi]) begin
                                state_reg <= TRACK;
                                cnt_reg   <= 6'd1;
                                match_reg <= '0;
                            end else begin
                                cnt_reg <= cnt_inc;
                            end
                        end
                        TRACK, LOCKED: begin
                            if (rise[gi]) begin
                                period_reg <= cnt_reg;
                                cnt_reg    <= 6'd1;
                                if (!is_match) begin
                                    state_reg <= TRACK;
                                    match_reg <= '0;
                                    lock_reg  <= 1'b0;
                                end else if (state_reg == TRACK) begin
                                    if (match_reg + 4'd1 == 4'(LOCK_CNT)) begin
                                        state_reg <= LOCKED;
                                        lock_reg  <= 1'b1;
                                    end
                                    match_reg <= match_reg + 4'd1;
                                end
                            end else if (timeout) begin
                                state_reg <= WAIT_EDGE;
                                cnt_reg   <= cnt_inc;
                                match_reg <= '0;
                                lock_reg  <= 1'b0;
                            end else begin
                                cnt_reg <= cnt_inc;
                            end
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end
        end

        assign lock[gi]       = lock_reg;
        assign err_pulse[gi]  = pulse_reg;
        assign err_sticky[gi] = sticky_reg;
    end

    assign period0 = g_ch[0].period_reg;
    assign period1 = g_ch[1].period_reg;
    assign period2 = g_ch[2].period_reg;
endmodule

// File: tb/tb_div_clk_monitor.sv
// Self-checking bench for div_clk_monitor: randomized divider stimulus against an
// edge-time reference model; honours CLK_MON_SYNC_EN for detection latency.
module tb_div_clk_monitor;
    localparam int TIMEOUT  = 32;
    localparam int LOCK_CNT = 4;
`ifdef CLK_MON_SYNC_EN
    localparam int DLY = 3;
`else
    localparam int DLY = 1;
`endif

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mon_in = '0;
    logic       err_clr = 1'b0;
    logic [2:0] lock, err_pulse, err_sticky;
    logic [5:0] period0, period1, period2;

    int checks = 0;
    int failures = 0;

    div_clk_monitor #(.EXP_P0(2), .EXP_P1(4), .EXP_P2(8), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .rst(rst), .en(en), .mon_in(mon_in), .err_clr(err_clr),
        .lock(lock), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .period0(period0), .period1(period1), .period2(period2)
    );

    always #5 clk_in = ~clk_in;

    // Stimulus generator: square waves with optional hold (stretch) per channel
    int exp_p[3] = '{2, 4, 8};
    int ph[3];
    int hold[3];

    // Reference model: edge times and run lengths
    logic [2:0] h[0:4];
    int  k = 0;
    bit  armed[3], have_ref[3], lck[3];
    int  run[3], last[3];
    logic [5:0] per_m[3];
    logic [2:0] pulse_m, sticky_m;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) h[i] = '0;
        for (int c = 0; c < 3; c++) begin
            armed[c] = 0; have_ref[c] = 0; lck[c] = 0; run[c] = 0; last[c] = 0; per_m[c] = '0;
        end
        pulse_m = '0; sticky_m = '0;
    endtask

    task automatic model_step();
        logic [2:0] r;
        logic [2:0] err;
        int p;
        k++;
        for (int i = 4; i > 0; i--) h[i] = h[i-1];
        h[0] = mon_in;
        r = h[DLY] & ~h[DLY+1];
        err = '0;
        for (int c = 0; c < 3; c++) begin
            if (!en) begin
                armed[c] = 0; have_ref[c] = 0; run[c] = 0; lck[c] = 0;
            end else if (!armed[c]) begin
                armed[c] = 1;
            end else if (r[c]) begin
                if (have_ref[c]) begin
                    p = k - last[c];
                    per_m[c] = 6'(p);
                    if (p == exp_p[c]) begin
                        if (!lck[c]) begin
                            run[c]++;
                            if (run[c] == LOCK_CNT) lck[c] = 1;
                        end
                    end else begin
                        if (lck[c]) err[c] = 1'b1;
                        lck[c] = 0; run[c] = 0;
                    end
                end else begin
                    have_ref[c] = 1; run[c] = 0;
                end
                last[c] = k;
            end else if (have_ref[c] && (k - last[c] == TIMEOUT - 1)) begin
                if (lck[c]) err[c] = 1'b1;
                lck[c] = 0; have_ref[c] = 0; run[c] = 0;
            end
        end
        pulse_m  = err;
        sticky_m = (sticky_m & ~{3{err_clr}}) | err;
    endtask

    function automatic logic [2:0] lock_vec();
        return {lck[2], lck[1], lck[0]};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".lock"}, 6'(lock), 6'(lock_vec()));
        chk({tag, ".err_pulse"}, 6'(err_pulse), 6'(pulse_m));
        chk({tag, ".err_sticky"}, 6'(err_sticky), 6'(sticky_m));
        chk({tag, ".period0"}, period0, per_m[0]);
        chk({tag, ".period1"}, period1, per_m[1]);
        chk({tag, ".period2"}, period2, per_m[2]);
    endtask

    task automatic gen_next();
        for (int c = 0; c < 3; c++) begin
            if (hold[c] > 0) hold[c]--;
            else ph[c] = (ph[c] + 1) % exp_p[c];
            mon_in[c] = (ph[c] < exp_p[c] / 2);
        end
    endtask

    task automatic tick(input string tag, input logic clr);
        gen_next();
        err_clr = clr;
        @(posedge clk_in);
        model_step();
        #1;
        check_all(tag);
        $display("cycle=%0d %s mon=%b en=%b clr=%b lock=%b pulse=%b sticky=%b per=%0d/%0d/%0d",
                 k, tag, mon_in, en, clr, lock, err_pulse, err_sticky, period0, period1, period2);
    endtask

    initial begin
        int lock_wait;
        for (int c = 0; c < 3; c++) begin
            ph[c] = $urandom_range(0, exp_p[c] - 1);
            hold[c] = 0;
        end
        model_reset();

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check_all("reset");
        @(negedge clk_in);
        rst = 1'b1;

        // Acquisition with clean dividers
        en = 1'b1;
        for (int i = 0; i < 50; i++) tick("acquire", 1'b0);
        chk("acquire.lock_all", 6'(lock), 6'(3'b111));
        chk("acquire.p0", period0, 6'd2);
        chk("acquire.p1", period1, 6'd4);
        chk("acquire.p2", period2, 6'd8);
        chk("acquire.sticky0", 6'(err_sticky), 6'd0);

        // Stretch one high phase of channel 2 by 2 cycles
        while (mon_in[2] !== 1'b1) tick("pre_stretch2", 1'b0);
        hold[2] = 2;
        lock_wait = 0;
        while (err_pulse[2] !== 1'b1 && lock_wait < 40) begin
            tick("stretch2", 1'b0);
            lock_wait++;
        end
        chk("stretch2.seen", 6'(lock_wait < 40), 6'd1);
        chk("stretch2.period", period2, 6'd10);
        chk("stretch2.lock", 6'(lock[2]), 6'd0);
        for (int i = 0; i < 50; i++) tick("relock2", 1'b0);
        chk("relock2.lock", 6'(lock[2]), 6'd1);

        // Hold channel 1 low for 40 cycles
        while (mon_in[1] !== 1'b0) tick("pre_hold1", 1'b0);
        hold[1] = 40;
        for (int i = 0; i < 40; i++) tick("hold1", 1'b0);
        chk("hold1.sticky", 6'(err_sticky[1]), 6'd1);
        chk("hold1.period", period1, 6'd4);
        for (int i = 0; i < 30; i++) tick("relock1", 1'b0);

        // err_clr held across a channel-0 error: simultaneous error wins, then clears
        for (int i = 0; i < 3; i++) tick("clr_only", 1'b1);
        while (mon_in[0] !== 1'b1) tick("pre_err0", 1'b1);
        hold[0] = 1;
        for (int i = 0; i < 8; i++) tick("err0_with_clr", 1'b1);
        chk("err0.sticky_cleared", 6'(err_sticky[0]), 6'd0);
        for (int i = 0; i < 20; i++) tick("relock0", 1'b0);

        // Reset pulse while locked
        @(negedge clk_in);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rst_pulse");
        chk("rst_pulse.lock", 6'(lock), 6'd0);
        @(negedge clk_in);
        rst = 1'b1;
        for (int i = 0; i < 50; i++) tick("reacquire", 1'b0);
        chk("reacquire.lock_all", 6'(lock), 6'(3'b111));

        // Random jitter, err_clr and enable drops
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 99) < 3) hold[c] = $urandom_range(1, 3);
            if ($urandom_range(0, 99) < 2) en = ~en;
            else if (!en && $urandom_range(0, 99) < 30) en = 1'b1;
            tick("random", ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
